// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - single-port data RAM arbiter between the CPU memory stage and an external requester
module data_mem_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic        ext_lock,
  input  logic [15:0] ext_addr,
  input  logic [15:0] ext_wdata,
  output logic        ext_gnt,
  output logic        ext_rvalid,
  output logic [15:0] ext_rdata,
  output logic [15:0] ram_address,
  output logic [15:0] ram_data,
  output logic        ram_wren,
  input  logic [15:0] ram_q
);

  localparam logic [1:0] ST_ARB      = 2'd0;
  localparam logic [1:0] ST_LOCKED   = 2'd1;
  localparam logic [1:0] ST_CPU_SLOT = 2'd2;
  localparam logic [3:0] WAIT_MAX    = 4'(MAX_WAIT);
  localparam logic [7:0] LOCK_MAX    = 8'(MAX_LOCK);

  logic [1:0]  state_q, state_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        cpu_rvalid_q, ext_rvalid_q;
  logic [15:0] cpu_rdata_q, ext_rdata_q;
  logic        arb_ext;
  logic        hold_lock;

  always_comb begin
    arb_ext    = ext_req & (~cpu_req | (starve_cnt_q == WAIT_MAX));
    hold_lock  = (state_q == ST_LOCKED) & ext_req & ext_lock;
    cpu_gnt    = 1'b0;
    ext_gnt    = 1'b0;
    state_d    = ST_ARB;
    lock_cnt_d = 8'd0;
    if (state_q == ST_CPU_SLOT) begin
      cpu_gnt = cpu_req;
      if (ext_req & ext_lock) state_d = ST_LOCKED;
    end else if (hold_lock) begin
      ext_gnt    = 1'b1;
      lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + 8'd1;
      state_d    = ST_LOCKED;
    end else begin
      // A dropped lock falls through to plain arbitration in the same cycle
      ext_gnt = arb_ext;
      cpu_gnt = cpu_req & ~arb_ext;
      if (arb_ext & ext_lock) begin
        state_d    = ST_LOCKED;
        lock_cnt_d = 8'd1;
      end
    end
    // lock_cnt counts locked grants; the one reaching MAX_LOCK hands the next cycle to the CPU
    if ((state_d == ST_LOCKED) && (lock_cnt_d == LOCK_MAX) && cpu_req && ext_gnt) begin
      state_d    = ST_CPU_SLOT;
      lock_cnt_d = 8'd0;
    end
    if (reset) begin
      cpu_gnt = 1'b0;
      ext_gnt = 1'b0;
    end
  end

  always_comb begin
    starve_cnt_d = 4'd0;
    if (ext_req & ~ext_gnt)
      starve_cnt_d = (starve_cnt_q == WAIT_MAX) ? starve_cnt_q : starve_cnt_q + 4'd1;
  end

  assign cpu_stall   = cpu_req & ~cpu_gnt;
  assign ram_address = ext_gnt ? ext_addr  : cpu_addr;
  assign ram_data    = ext_gnt ? ext_wdata : cpu_wdata;
  assign ram_wren    = (cpu_gnt & cpu_we) | (ext_gnt & ext_we);

  assign cpu_rvalid = cpu_rvalid_q;
  assign ext_rvalid = ext_rvalid_q;
  assign cpu_rdata  = cpu_rvalid_q ? ram_q : cpu_rdata_q;
  assign ext_rdata  = ext_rvalid_q ? ram_q : ext_rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_ARB;
      lock_cnt_q   <= 8'd0;
      starve_cnt_q <= 4'd0;
      cpu_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
      cpu_rdata_q  <= 16'd0;
      ext_rdata_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      cpu_rvalid_q <= cpu_gnt & ~cpu_we;
      ext_rvalid_q <= ext_gnt & ~ext_we;
      if (cpu_rvalid_q) cpu_rdata_q <= ram_q;
      if (ext_rvalid_q) ext_rdata_q <= ram_q;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed scenarios plus randomized checking against a reference model
module tb_data_mem_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int MAX_LOCK = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, ext_req, ext_we, ext_lock;
  logic [15:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid, ram_wren;
  logic [15:0] cpu_rdata, ext_rdata, ram_address, ram_data, ram_q;

  logic [15:0] mem [0:65535];
  logic [15:0] ref_mem [0:15];
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = 16'd0, pre_data = 16'd0;

  int errors = 0;
  int checks = 0;

  int m_lost, m_burst;
  bit m_lock, m_slot;

  data_mem_arbiter #(.MAX_WAIT(MAX_WAIT), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered address; pre_* is a bench-side loader used while idle
  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    else if (pre_we) mem[pre_addr] <= pre_data;
    ram_q <= mem[ram_address];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle;
    cpu_req = 0; cpu_we = 0; cpu_addr = 16'd0; cpu_wdata = 16'd0;
    ext_req = 0; ext_we = 0; ext_lock = 0; ext_addr = 16'd0; ext_wdata = 16'd0;
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    step;
    pre_we = 1'b0;
  endtask

  // Grant rules: owed CPU slot, then a held lock, then starvation-limited CPU priority
  function automatic void predict(output bit cg, output bit eg);
    if (reset) begin
      cg = 0; eg = 0;
    end else if (m_slot) begin
      cg = cpu_req; eg = 0;
    end else if (m_lock && ext_req && ext_lock) begin
      cg = 0; eg = 1;
    end else begin
      eg = ext_req && (!cpu_req || m_lost == MAX_WAIT);
      cg = cpu_req && !eg;
    end
  endfunction

  task automatic model_advance(input bit cg, input bit eg);
    if (reset) begin
      m_lost = 0; m_burst = 0; m_lock = 0; m_slot = 0;
    end else begin
      m_lost = (ext_req && !eg) ? ((m_lost < MAX_WAIT) ? m_lost + 1 : MAX_WAIT) : 0;
      if (m_slot) begin
        m_slot = 0; m_lock = ext_req && ext_lock; m_burst = 0;
      end else if (eg && ext_lock) begin
        m_burst = m_lock ? ((m_burst < MAX_LOCK) ? m_burst + 1 : MAX_LOCK) : 1;
        m_lock  = 1;
        if (m_burst == MAX_LOCK && cpu_req) begin
          m_slot = 1; m_lock = 0; m_burst = 0;
        end
      end else begin
        m_lock = 0; m_burst = 0;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1; cpu_req = 1; ext_req = 1; ext_we = 1; cpu_we = 1;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, ext_gnt, ram_wren, cpu_stall} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_outputs: gnt/gnt/wren/stall=%b expected 0001", {cpu_gnt, ext_gnt, ram_wren, cpu_stall});
    end
    step;
    reset = 0; set_idle;
    @(negedge clk);
    checks++;
    if ({cpu_rvalid, ext_rvalid, cpu_rdata, ext_rdata} !== 34'd0) begin
      errors++;
      $display("FAIL reset_values: rvalid=%b%b rdata=%h/%h expected 0", cpu_rvalid, ext_rvalid, cpu_rdata, ext_rdata);
    end
    step;
  endtask

  task automatic test_cpu_read;
    poke(16'h0010, 16'hBEEF);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, cpu_stall, ram_wren, ram_address} !== {3'b100, 16'h0010}) begin
      errors++;
      $display("FAIL cpu_read_grant: gnt=%b stall=%b wren=%b addr=%h expected 1 0 0 0010", cpu_gnt, cpu_stall, ram_wren, ram_address);
    end
    step;
    set_idle;
    @(negedge clk);
    checks++;
    if ({cpu_rvalid, ext_rvalid, cpu_rdata} !== {2'b10, 16'hBEEF}) begin
      errors++;
      $display("FAIL cpu_read_data: rvalid=%b/%b rdata=%h expected 1/0 beef", cpu_rvalid, ext_rvalid, cpu_rdata);
    end
    step;
    @(negedge clk);
    checks++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b0, 16'hBEEF}) begin
      errors++;
      $display("FAIL cpu_read_hold: rvalid=%b rdata=%h expected 0 beef", cpu_rvalid, cpu_rdata);
    end
    step;
  endtask

  task automatic test_contention;
    bit e;
    cpu_req = 1; cpu_addr = 16'h0010; ext_req = 1; ext_addr = 16'h0011; ext_lock = 0;
    for (int i = 0; i < 10; i++) begin
      e = (i % 5 == 4);
      @(negedge clk);
      checks++;
      if ({cpu_gnt, ext_gnt, cpu_stall} !== {!e, e, e}) begin
        errors++;
        $display("FAIL contention_c%0d: cpu/ext/stall=%b expected %b", i, {cpu_gnt, ext_gnt, cpu_stall}, {!e, e, e});
      end
      step;
    end
    set_idle;
    step;
  endtask

  task automatic test_lock;
    logic [14:0] e_pat;
    int k;
    e_pat = 15'b110_11111111_0000;
    k = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020; ext_req = 1; ext_we = 1; ext_lock = 1;
    for (int i = 0; i < 15; i++) begin
      ext_addr = 16'h0100 + 16'(k); ext_wdata = 16'hA000 + 16'(k);
      @(negedge clk);
      checks++;
      if ({cpu_gnt, ext_gnt} !== {!e_pat[i], e_pat[i]}) begin
        errors++;
        $display("FAIL lock_c%0d: cpu/ext=%b expected %b", i, {cpu_gnt, ext_gnt}, {!e_pat[i], e_pat[i]});
      end
      if (ext_gnt) k++;
      step;
    end
    set_idle;
    step;
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (mem[16'h0100 + 16'(j)] !== 16'hA000 + 16'(j)) begin
        errors++;
        $display("FAIL lock_ram_%0d: mem=%h expected %h", j, mem[16'h0100 + 16'(j)], 16'hA000 + 16'(j));
      end
    end
  endtask

  task automatic test_lock_release;
    bit e;
    ext_req = 1; ext_lock = 1; ext_we = 0; ext_addr = 16'h0100;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin cpu_req = 1; cpu_addr = 16'h0020; end
      if (i == 3) ext_lock = 0;
      e = (i < 3) || (i == 7);
      @(negedge clk);
      checks++;
      if ({cpu_gnt, ext_gnt} !== {cpu_req & !e, e}) begin
        errors++;
        $display("FAIL lock_release_c%0d: cpu/ext=%b expected %b", i, {cpu_gnt, ext_gnt}, {cpu_req & !e, e});
      end
      step;
    end
    set_idle;
    step;
  endtask

  task automatic test_reset_mid_read;
    poke(16'h0030, 16'h1234);
    ext_req = 1; ext_we = 0; ext_addr = 16'h0030;
    @(negedge clk);
    checks++;
    if (ext_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rst_read_grant: ext_gnt=%b expected 1", ext_gnt);
    end
    step;
    reset = 1; cpu_req = 1; cpu_we = 1;
    @(negedge clk);
    checks++;
    if ({ext_rvalid, ext_rdata, cpu_gnt, ext_gnt, ram_wren, cpu_stall} !== {1'b1, 16'h1234, 4'b0001}) begin
      errors++;
      $display("FAIL rst_read_cycle: rvalid=%b rdata=%h gnt=%b%b wren=%b stall=%b expected 1 1234 00 0 1",
               ext_rvalid, ext_rdata, cpu_gnt, ext_gnt, ram_wren, cpu_stall);
    end
    step;
    reset = 0; cpu_we = 0; cpu_addr = 16'h0010;
    @(negedge clk);
    checks++;
    if ({cpu_rvalid, ext_rvalid, ext_rdata, cpu_gnt, ext_gnt} !== {2'b00, 16'h0000, 2'b10}) begin
      errors++;
      $display("FAIL rst_read_after: rvalid=%b%b ext_rdata=%h gnt=%b%b expected 00 0000 10",
               cpu_rvalid, ext_rvalid, ext_rdata, cpu_gnt, ext_gnt);
    end
    step;
    set_idle;
    step;
  endtask

  task automatic test_alternating;
    poke(16'h0001, 16'h1111);
    poke(16'h0002, 16'h2222);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0001;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, ext_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL alt_c0: cpu/ext=%b expected 10", {cpu_gnt, ext_gnt});
    end
    step;
    cpu_req = 0; ext_req = 1; ext_we = 0; ext_addr = 16'h0002;
    @(negedge clk);
    checks++;
    if ({ext_gnt, cpu_rvalid, ext_rvalid, cpu_rdata} !== {3'b110, 16'h1111}) begin
      errors++;
      $display("FAIL alt_c1: ext_gnt=%b rvalid=%b%b cpu_rdata=%h expected 1 10 1111", ext_gnt, cpu_rvalid, ext_rvalid, cpu_rdata);
    end
    step;
    set_idle;
    @(negedge clk);
    checks++;
    if ({cpu_rvalid, ext_rvalid, ext_rdata, cpu_rdata} !== {2'b01, 16'h2222, 16'h1111}) begin
      errors++;
      $display("FAIL alt_c2: rvalid=%b%b ext_rdata=%h cpu_rdata=%h expected 01 2222 1111", cpu_rvalid, ext_rvalid, ext_rdata, cpu_rdata);
    end
    step;
  endtask

  task automatic test_random;
    bit cg, eg, pcv, pev;
    logic [15:0] v, exp_crd, exp_erd, exp_addr;
    for (int a = 0; a < 16; a++) begin
      v = 16'($urandom);
      ref_mem[a] = v;
      poke(16'(a), v);
    end
    reset = 1;
    step;
    reset = 0;
    m_lost = 0; m_burst = 0; m_lock = 0; m_slot = 0;
    pcv = 0; pev = 0; exp_crd = 16'd0; exp_erd = 16'd0;
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 63) == 0);
      cpu_req   = ($urandom_range(0, 3) != 0);
      cpu_we    = $urandom_range(0, 1) == 1;
      cpu_addr  = 16'($urandom_range(0, 15));
      cpu_wdata = 16'($urandom);
      ext_req   = ($urandom_range(0, 2) != 0);
      ext_we    = $urandom_range(0, 1) == 1;
      ext_lock  = ($urandom_range(0, 3) != 0);
      ext_addr  = 16'($urandom_range(0, 15));
      ext_wdata = 16'($urandom);
      @(negedge clk);
      predict(cg, eg);
      exp_addr = eg ? ext_addr : cpu_addr;
      checks++;
      if ({cpu_gnt, ext_gnt, cpu_stall, ram_wren, ram_address} !==
          {cg, eg, cpu_req & !cg, (cg & cpu_we) | (eg & ext_we), exp_addr}) begin
        errors++;
        $display("FAIL rand_grant_%0d: gnt=%b%b stall=%b wren=%b addr=%h expected %b%b %b %b %h", n,
                 cpu_gnt, ext_gnt, cpu_stall, ram_wren, ram_address,
                 cg, eg, cpu_req & !cg, (cg & cpu_we) | (eg & ext_we), exp_addr);
      end
      if ((cg & cpu_we) | (eg & ext_we)) begin
        checks++;
        if (ram_data !== (eg ? ext_wdata : cpu_wdata)) begin
          errors++;
          $display("FAIL rand_wdata_%0d: ram_data=%h expected %h", n, ram_data, eg ? ext_wdata : cpu_wdata);
        end
      end
      checks++;
      if ({cpu_rvalid, ext_rvalid, cpu_rdata, ext_rdata} !== {pcv, pev, exp_crd, exp_erd}) begin
        errors++;
        $display("FAIL rand_read_%0d: rvalid=%b%b rdata=%h/%h expected %b%b %h/%h", n,
                 cpu_rvalid, ext_rvalid, cpu_rdata, ext_rdata, pcv, pev, exp_crd, exp_erd);
      end
      @(posedge clk);
      pcv = cg && !cpu_we;
      pev = eg && !ext_we;
      if (pcv) exp_crd = ref_mem[cpu_addr[3:0]];
      if (pev) exp_erd = ref_mem[ext_addr[3:0]];
      if (reset) begin exp_crd = 16'd0; exp_erd = 16'd0; end
      if (cg && cpu_we) ref_mem[cpu_addr[3:0]] = cpu_wdata;
      if (eg && ext_we) ref_mem[ext_addr[3:0]] = ext_wdata;
      model_advance(cg, eg);
      #1;
    end
    reset = 0;
    set_idle;
    step;
  endtask

  initial begin
    reset = 1;
    set_idle;
    step;
    test_reset;
    test_cpu_read;
    test_contention;
    test_lock;
    test_lock_release;
    test_reset_mid_read;
    test_alternating;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
